// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared constants, scan-code lookup and FSM encoding for ps2_key_decoder
//
// Purpose: key index map for the Set-2 scan codes we care about, prefix bytes,
//          the ignored-byte list, the (ext, code) -> key index lookup, and the
//          decoder FSM state encoding.
// Ports:   none (package).
package ps2_key_pkg;

  localparam int NKEY = 13;

  localparam logic [3:0] KEY_W     = 4'd0;
  localparam logic [3:0] KEY_A     = 4'd1;
  localparam logic [3:0] KEY_S     = 4'd2;
  localparam logic [3:0] KEY_D     = 4'd3;
  localparam logic [3:0] KEY_SPACE = 4'd4;
  localparam logic [3:0] KEY_J     = 4'd5;
  localparam logic [3:0] KEY_K     = 4'd6;
  localparam logic [3:0] KEY_ENTER = 4'd7;
  localparam logic [3:0] KEY_ESC   = 4'd8;
  localparam logic [3:0] KEY_UP    = 4'd9;
  localparam logic [3:0] KEY_DOWN  = 4'd10;
  localparam logic [3:0] KEY_LEFT  = 4'd11;
  localparam logic [3:0] KEY_RIGHT = 4'd12;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // FSM encoding kept as plain constants so legacy tooling can read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POP  = 2'd1;
  localparam state_t ST_DEC  = 2'd2;

  // Keyboard housekeeping bytes (pause prefix, BAT ok, ack, echo, resend,
  // errors). They cancel any pending prefix and never produce events.
  function automatic logic sc_ignored(input logic [7:0] code);
    case (code)
      8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // Returns {hit, idx}. Extended and plain codes live in separate tables so a
  // bare 75 never aliases to Up.
  function automatic logic [4:0] sc_lookup(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = 5'b0;
    if (!ext) begin
      case (code)
        8'h1D:   r = {1'b1, KEY_W};
        8'h1C:   r = {1'b1, KEY_A};
        8'h1B:   r = {1'b1, KEY_S};
        8'h23:   r = {1'b1, KEY_D};
        8'h29:   r = {1'b1, KEY_SPACE};
        8'h3B:   r = {1'b1, KEY_J};
        8'h42:   r = {1'b1, KEY_K};
        8'h5A:   r = {1'b1, KEY_ENTER};
        8'h76:   r = {1'b1, KEY_ESC};
        default: r = 5'b0;
      endcase
    end else begin
      case (code)
        8'h75:   r = {1'b1, KEY_UP};
        8'h72:   r = {1'b1, KEY_DOWN};
        8'h6B:   r = {1'b1, KEY_LEFT};
        8'h74:   r = {1'b1, KEY_RIGHT};
        default: r = 5'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - receiver FIFO handshake bundle
//
// Purpose: groups the PS/2 receiver FIFO head, status and pop strobe.
// Signals: kbd_data[7:0] FIFO head byte, kbd_ready FIFO non-empty,
//          kbd_overflow receiver overflow flag, kbd_rdn active-low pop.
// Modports: master = FIFO side, slave = decoder side.
interface ps2_key_decoder_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_rdn;

  modport master (
    output kbd_data,
    output kbd_ready,
    output kbd_overflow,
    input  kbd_rdn
  );

  modport slave (
    input  kbd_data,
    input  kbd_ready,
    input  kbd_overflow,
    output kbd_rdn
  );
endinterface

// File: rtl/ps2_prefix_timer.sv
// rtl/ps2_prefix_timer.sv - idle timeout for a pending break/extended prefix
//
// Purpose: counts enabled cycles; flags expiry on the TIMEOUT_CYC-th one and
//          wraps back to zero.
// Ports: clk, clrn (sync active-low reset), clr_i (restart count),
//        en_i (count this cycle), expire_o (combinational, this cycle expires).
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - Set-2 make/break decoder draining the PS/2 receiver FIFO
//
// Purpose: pops one byte per 3 cycles, tracks F0/E0 prefixes, keeps a held-key
//          vector and emits a one-cycle event per decoded key transition.
// Ports: clk, clrn (sync active-low reset), kbd (FIFO handshake, slave side),
//        key_down[12:0] held keys, evt_valid strobe, evt_key index,
//        evt_make (1 press / 0 release).
// Build option: PS2_TYPEMATIC_FILTER_EN suppresses events for makes of keys
//               already held (typematic repeats).
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              clrn,
  ps2_key_decoder_if.slave  kbd,
  output logic [NKEY-1:0]   key_down,
  output logic              evt_valid,
  output logic [3:0]        evt_key,
  output logic              evt_make
);

  state_t          state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic            brk_q, brk_d;
  logic            ext_q, ext_d;
  logic            rdn_q, rdn_d;
  logic [NKEY-1:0] key_down_q, key_down_d;
  logic            evt_valid_q, evt_valid_d;
  logic [3:0]      evt_key_q, evt_key_d;
  logic            evt_make_q, evt_make_d;

  logic            tmr_clr, tmr_en, tmr_expire;
  logic [4:0]      lk;
  logic            lk_hit;
  logic [3:0]      lk_idx;

  assign lk     = sc_lookup(ext_q, byte_q);
  assign lk_hit = lk[4] && !sc_ignored(byte_q);
  assign lk_idx = lk[3:0];

  ps2_prefix_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_prefix_timer (
    .clk      (clk),
    .clrn     (clrn),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    rdn_d       = 1'b1;
    key_down_d  = key_down_q;
    evt_valid_d = 1'b0;
    evt_key_d   = evt_key_q;
    evt_make_d  = evt_make_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_en = (brk_q || ext_q) && !kbd.kbd_ready;
        if (tmr_expire) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
        // Overflow means bytes were dropped, so held state can no longer be
        // trusted; placed after the timeout so it wins on the same cycle.
        if (kbd.kbd_overflow) begin
          key_down_d = '0;
          brk_d      = 1'b0;
          ext_d      = 1'b0;
        end
        if (kbd.kbd_ready) begin
          byte_d  = kbd.kbd_data;
          rdn_d   = 1'b0;
          tmr_clr = 1'b1;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        state_d = ST_DEC;
      end

      ST_DEC: begin
        state_d = ST_IDLE;
        if (byte_q == SC_BREAK) begin
          brk_d = 1'b1;
        end else if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (lk_hit) begin
            if (brk_q) begin
              key_down_d[lk_idx] = 1'b0;
              evt_valid_d        = 1'b1;
              evt_key_d          = lk_idx;
              evt_make_d         = 1'b0;
            end else begin
              key_down_d[lk_idx] = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (!key_down_q[lk_idx]) begin
                evt_valid_d = 1'b1;
                evt_key_d   = lk_idx;
                evt_make_d  = 1'b1;
              end
`else
              evt_valid_d = 1'b1;
              evt_key_d   = lk_idx;
              evt_make_d  = 1'b1;
`endif
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      byte_q      <= 8'h00;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      rdn_q       <= 1'b1;
      key_down_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= 4'd0;
      evt_make_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      rdn_q       <= rdn_d;
      key_down_q  <= key_down_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_make_q  <= evt_make_d;
    end
  end

  assign kbd.kbd_rdn = rdn_q;
  assign key_down    = key_down_q;
  assign evt_valid   = evt_valid_q;
  assign evt_key     = evt_key_q;
  assign evt_make    = evt_make_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequencing controller for the PS/2 receiver FIFO. Drains scan-code bytes through the `data`/`ready`/`rdn` handshake, decodes Set-2 make/break sequences (including the `F0` break and `E0` extended prefixes), and maintains a held-key vector plus a per-key event strobe. Sits between the PS/2 receiver and the game-control logic, replacing ad-hoc per-key decoding.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 2_000_000: idle cycles after which a pending prefix is discarded (20 ms at 100 MHz).

Ports:
- `clk`, in, 1: system clock.
- `clrn`, in, 1: reset. Synchronous, active-low; sampled on the rising edge of `clk`.
- `kbd_data`, in, 8: FIFO head byte, combinational from the receiver.
- `kbd_ready`, in, 1: FIFO non-empty.
- `kbd_overflow`, in, 1: receiver FIFO overflow flag.
- `kbd_rdn`, out, 1: active-low pop; registered.
- `key_down`, out, 13: held state per key index.
- `evt_valid`, out, 1: one-cycle event strobe.
- `evt_key`, out, 4: key index of the event.
- `evt_make`, out, 1: 1 = press, 0 = release.

## Operation

- Key index map (Set 2), 0–12:
  - 0 W `1D`, 1 A `1C`, 2 S `1B`, 3 D `23`
  - 4 Space `29`, 5 J `3B`, 6 K `42`, 7 Enter `5A`, 8 Esc `76`
  - 9 Up `E0 75`, 10 Down `E0 72`, 11 Left `E0 6B`, 12 Right `E0 74`
- FSM states: IDLE, POP, DEC.
  - IDLE with `kbd_ready`=1: latch `kbd_data` into `byte_r`, drive `kbd_rdn`<=0, go to POP.
  - POP: `kbd_rdn`<=1, go to DEC.
  - DEC: decode `byte_r`, go to IDLE.
- Decode rules in DEC:
  - `F0`: set `brk`.
  - `E0`: set `ext`.
  - `E1`, `AA`, `FA`, `EE`, `FE`, `00`, `FF`: ignored; clear `brk` and `ext`.
  - Any other byte: look up the (`ext`, byte) pair.
    - On a hit with `brk`=0: set `key_down[i]`, pulse event with `evt_make`=1.
    - On a hit with `brk`=1: clear `key_down[i]`, pulse event with `evt_make`=0.
    - On a miss: no event.
    - Clear `brk` and `ext` in every case.
  - A non-extended byte that matches only an extended entry (e.g. `75` without `E0`) is a miss.
- Prefix timeout:
  - 32-bit-safe counter, width `$clog2(TIMEOUT_CYC)`.
  - Counts in IDLE while `brk|ext` is set and `kbd_ready`=0; resets whenever a byte is latched.
  - At `TIMEOUT_CYC-1`: clear `brk` and `ext`, reset the counter.
- Overflow resync:
  - While `kbd_overflow`=1 and the state is IDLE: clear `key_down`, `brk` and `ext`. No events are produced.
  - Draining continues normally.
  - Overflow has priority over a same-cycle timeout.

## Timing

- Reset values: `kbd_rdn`=1, `key_down`=0, `evt_valid`=0, `evt_key`=0, `evt_make`=0. Internally: state IDLE, `brk`=`ext`=0, timer 0.
- Per-byte sequence, with `kbd_ready` seen at edge t:
  - `kbd_rdn` is low for exactly one cycle, between edges t and t+1. The FIFO pops at t+1.
  - Decode happens at edge t+2. `evt_valid`/`key_down` are visible from t+2 to t+3.
  - The next `kbd_ready` is sampled at t+3. Throughput is one byte per 3 cycles.
- `kbd_data` is sampled only at the IDLE→POP edge, never while `kbd_rdn` is low.
- `evt_key`/`evt_make` hold their last value when `evt_valid`=0.
- Reset asserted mid-sequence (POP or DEC): the latched byte is discarded and `kbd_rdn` returns to 1 on the reset edge. A byte already popped is lost.

## Configuration

- `PS2_TYPEMATIC_FILTER_EN`
  - Defined: a make for a key whose `key_down` bit is already set produces no event. Typematic repeats are suppressed.
  - Undefined: every make produces an event.
  - `key_down` behaviour is identical in both cases.

## Structure

- Package `ps2_key_pkg`:
  - Constants: `NKEY`=13, key index localparams (`KEY_W`…`KEY_RIGHT`), prefix bytes `SC_BREAK`=`8'hF0` and `SC_EXT`=`8'hE0`, and the ignored-byte list.
  - A function `sc_lookup(ext, code)` returning {hit, idx[3:0]}.
  - The FSM state enum.
- One sub-module is natural: `ps2_prefix_timer`, holding the timeout counter with clear/enable inputs and an expire output.

## Test plan

- Feed `1D`, then `F0 1D` -> event (0, make=1) with `key_down[0]`=1, then event (0, make=0) with `key_down[0]`=0. `kbd_rdn` is low for exactly one cycle per byte.
- Feed `E0 75`, then `E0 F0 75`, then a bare `75` -> events (9, 1) and (9, 0); the bare `75` produces no event.
- Feed `23 23 23`: filter macro defined -> one event (3, 1); undefined -> three events.
- Feed `F0` then idle `TIMEOUT_CYC` cycles, then `1C` -> event (1, make=1), not a release.
- With W and D held, raise `kbd_overflow` -> `key_down`=0 and no events; a following `1B` -> event (2, 1).
- Pulse `clrn` low during POP -> all outputs return to reset values and `kbd_rdn`=1 on that edge; the next byte decodes with no prefix carry-over.
